// File: rtl/timer_uart_periph_pkg.sv
// Shared constants and types for the timer/UART peripheral.
package periph_pkg;

  // Word offsets inside the 16-byte timer window.
  localparam logic [3:0] TIMER_MTIME_LO    = 4'h0;
  localparam logic [3:0] TIMER_MTIME_HI    = 4'h4;
  localparam logic [3:0] TIMER_MTIMECMP_LO = 4'h8;
  localparam logic [3:0] TIMER_MTIMECMP_HI = 4'hC;

  // Word offsets inside the 8-byte UART window.
  localparam logic [2:0] UART_TXDATA = 3'h0;
  localparam logic [2:0] UART_STATUS = 3'h4;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_tx.sv
// 8N1 transmit serializer; one frame per accepted start, starts ignored while busy.
//
// state      | meaning
// -----------+---------------------------------------------------
// UART_IDLE  | line high, waiting for start_i
// UART_START | driving the start bit (0)
// UART_DATA  | shifting out data bits LSB first, idx_q = bit number
// UART_STOP  | driving the stop bit (1); busy ends with this bit
module uart_tx
  import periph_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       busy_o,
  output logic       tx_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;

  // State, bit timer, shift register and registered line output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= UART_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  // Next state: the bit timer counts down and each terminal count advances one bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    case (state_q)
      UART_IDLE: begin
        if (start_i) begin
          state_d = UART_START;
          cnt_d   = CNT_RELOAD;
          shreg_d = data_i;
          tx_d    = 1'b0;
        end
      end
      UART_START: begin
        if (cnt_q == '0) begin
          state_d = UART_DATA;
          cnt_d   = CNT_RELOAD;
          idx_d   = '0;
          tx_d    = shreg_q[0];
          shreg_d = {1'b0, shreg_q[7:1]};
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      UART_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_RELOAD;
          if (idx_q == 3'd7) begin
            state_d = UART_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            tx_d    = shreg_q[0];
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      UART_STOP: begin
        if (cnt_q == '0) begin
          state_d = UART_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = UART_IDLE;
    endcase
  end

  assign busy_o = (state_q != UART_IDLE);
  assign tx_o   = tx_q;

endmodule

// File: rtl/timer_uart_periph.sv
// Bus-mapped RISC-V machine timer plus transmit-only UART with its own address decode.
module timer_uart_periph
  import periph_pkg::*;
#(
  parameter logic [31:0] TIMER_BASE   = 32'h0200_0000,
  parameter logic [31:0] UART_BASE    = 32'h1000_0000,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  input  logic        read_enable,
  output logic [31:0] read_data,
  output logic        timer_valid,
  output logic        uart_valid,
  output logic        timer_interrupt,
  output logic        tx
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        irq_q;
  logic        uart_busy;

  // Windows are base-aligned, so the decode is a compare of the upper address bits.
  logic       access, timer_sel, uart_sel, uart_mapped;
  logic [3:0] timer_off;
  logic [2:0] uart_off;
  logic       unused_addr_bits;

  assign access      = read_enable | write_enable;
  assign timer_sel   = (addr[31:4] == TIMER_BASE[31:4]);
  assign uart_sel    = (addr[31:3] == UART_BASE[31:3]);
  assign timer_off   = {addr[3:2], 2'b00};
  assign uart_off    = {addr[2], 2'b00};
  assign uart_mapped = (uart_off == UART_TXDATA) || (uart_off == UART_STATUS);
  assign unused_addr_bits = ^addr[1:0];

  assign timer_valid = access & timer_sel;
  assign uart_valid  = access & uart_sel & uart_mapped;

  logic wr_timer;
  assign wr_timer = write_enable & timer_sel;

  // A written mtime half replaces the count for that cycle instead of incrementing.
  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    if (wr_timer) begin
      case (timer_off)
        TIMER_MTIME_LO:    mtime_d    = {mtime_q[63:32], write_data};
        TIMER_MTIME_HI:    mtime_d    = {write_data, mtime_q[31:0]};
        TIMER_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], write_data};
        TIMER_MTIMECMP_HI: mtimecmp_d = {write_data, mtimecmp_q[31:0]};
        default: ;
      endcase
    end
  end

  // Timer registers; the interrupt is the registered compare of the stored values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= (mtime_q >= mtimecmp_q);
    end
  end

  assign timer_interrupt = irq_q;

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk    (clk),
    .rst    (rst),
    .start_i(write_enable & uart_sel & (uart_off == UART_TXDATA)),
    .data_i (write_data[7:0]),
    .busy_o (uart_busy),
    .tx_o   (tx)
  );

  // Combinational load mux; TXDATA and unmapped offsets read as zero.
  always_comb begin
    read_data = '0;
    if (read_enable && timer_sel) begin
      case (timer_off)
        TIMER_MTIME_LO:    read_data = mtime_q[31:0];
        TIMER_MTIME_HI:    read_data = mtime_q[63:32];
        TIMER_MTIMECMP_LO: read_data = mtimecmp_q[31:0];
        TIMER_MTIMECMP_HI: read_data = mtimecmp_q[63:32];
        default:           read_data = '0;
      endcase
    end else if (read_enable && uart_sel && (uart_off == UART_STATUS)) begin
      read_data = {31'b0, uart_busy};
    end
  end

endmodule

// File: tb/tb_timer_uart_periph.sv
// Randomized scoreboard bench: expected loads are queued at issue time and popped by a monitor.
module tb_timer_uart_periph;

  localparam logic [31:0] TB_BASE = 32'h0200_0000;
  localparam logic [31:0] UB_BASE = 32'h1000_0000;
  localparam int CPB = 16;
  localparam longint unsigned FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic        write_enable = 1'b0;
  logic        read_enable = 1'b0;
  logic [31:0] read_data;
  logic        timer_valid, uart_valid, timer_interrupt, tx;

  timer_uart_periph #(
    .TIMER_BASE(TB_BASE), .UART_BASE(UB_BASE), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .write_data(write_data),
    .write_enable(write_enable), .read_enable(read_enable), .read_data(read_data),
    .timer_valid(timer_valid), .uart_valid(uart_valid),
    .timer_interrupt(timer_interrupt), .tx(tx)
  );

  always #5 clk = ~clk;

  longint unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model: mtime is a linear function of the cycle count since its last write.
  logic [63:0]     mt_base, mt_old_base, cmp_new, cmp_old;
  longint unsigned mt_cyc, mt_old_cyc, cmp_cyc, acc_cyc;
  logic            acc_valid;
  logic [7:0]      acc_byte;
  logic            irq_prev;
  logic            mon_en = 1'b0;

  function automatic logic [63:0] mtime_at(input longint unsigned c);
    if (c >= mt_cyc) return mt_base + 64'(c - mt_cyc);
    return mt_old_base + 64'(c - mt_old_cyc);
  endfunction

  function automatic logic [63:0] cmp_at(input longint unsigned c);
    return (c >= cmp_cyc) ? cmp_new : cmp_old;
  endfunction

  function automatic logic busy_at(input longint unsigned c);
    return acc_valid && (c > acc_cyc) && (c <= acc_cyc + FRAME);
  endfunction

  function automatic logic tx_at(input longint unsigned c);
    longint unsigned k;
    int b;
    if (!acc_valid || c <= acc_cyc || c > acc_cyc + FRAME) return 1'b1;
    k = c - acc_cyc - 1;
    b = int'(k / CPB);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return acc_byte[b-1];
  endfunction

  function automatic logic in_timer(input logic [31:0] a);
    return (a - TB_BASE) < 32'd16;
  endfunction

  function automatic logic in_uart(input logic [31:0] a);
    return (a - UB_BASE) < 32'd8;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a, input longint unsigned c);
    logic [31:0] off;
    logic [63:0] v;
    if (in_timer(a)) begin
      off = (a - TB_BASE) & ~32'd3;
      v = (off < 32'd8) ? mtime_at(c) : cmp_at(c);
      return (off == 32'd0 || off == 32'd8) ? v[31:0] : v[63:32];
    end
    if (in_uart(a)) begin
      off = (a - UB_BASE) & ~32'd3;
      return (off == 32'd4) ? {31'b0, busy_at(c)} : 32'd0;
    end
    return 32'd0;
  endfunction

  task automatic model_reset(input longint unsigned c);
    mt_base = '0; mt_cyc = c; mt_old_base = '0; mt_old_cyc = c;
    cmp_new = '1; cmp_old = '1; cmp_cyc = 0;
    acc_valid = 1'b0; acc_cyc = 0; acc_byte = '0;
    irq_prev = 1'b0;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input longint unsigned c);
    logic [63:0] cur;
    logic [31:0] off;
    if (in_timer(a)) begin
      off = (a - TB_BASE) & ~32'd3;
      if (off < 32'd8) begin
        cur = mtime_at(c);
        mt_old_base = mt_base; mt_old_cyc = mt_cyc;
        mt_base = (off == 32'd0) ? {cur[63:32], d} : {d, cur[31:0]};
        mt_cyc = c + 1;
      end else begin
        cur = cmp_at(c);
        cmp_old = cur;
        cmp_new = (off == 32'd8) ? {cur[63:32], d} : {d, cur[31:0]};
        cmp_cyc = c + 1;
      end
    end else if (in_uart(a)) begin
      off = (a - UB_BASE) & ~32'd3;
      if (off == 32'd0 && !busy_at(c)) begin
        acc_valid = 1'b1; acc_cyc = c; acc_byte = d[7:0];
      end
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        tv;
    logic        uv;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  string   nm_q[$];

  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic r, input string nm);
    rd_exp_t e;
    @(posedge clk); #1;
    addr = a; write_data = d; write_enable = w; read_enable = r;
    if (r) begin
      e.data = exp_read(a, cyc);
      e.tv = in_timer(a);
      e.uv = in_uart(a);
      exp_q.push_back(e);
      nm_q.push_back(nm);
    end
    if (w) model_write(a, d, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      addr = '0; write_data = '0; write_enable = 1'b0; read_enable = 1'b0;
    end
  endtask

  // Monitor: per-cycle line/interrupt checks, and a scoreboard pop on every load.
  rd_exp_t mon_e;
  string   mon_nm;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("irq", {63'b0, timer_interrupt}, {63'b0, irq_prev});
      chk("tx", {63'b0, tx}, {63'b0, tx_at(cyc)});
      irq_prev = (mtime_at(cyc) >= cmp_at(cyc));
      if (read_enable) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL rd_queue: got a load with no expectation queued, addr %h", addr);
        end else begin
          mon_e = exp_q.pop_front();
          mon_nm = nm_q.pop_front();
          chk({mon_nm, "_data"}, {32'b0, read_data}, {32'b0, mon_e.data});
          chk({mon_nm, "_tvalid"}, {63'b0, timer_valid}, {63'b0, mon_e.tv});
          chk({mon_nm, "_uvalid"}, {63'b0, uart_valid}, {63'b0, mon_e.uv});
        end
      end
    end
  end

  logic [31:0] tgt;
  logic [63:0] tmp;
  logic [31:0] ra;
  int          sel;

  initial begin
    model_reset(0);
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset(cyc);
    mon_en = 1'b1;
    chk("rst_tx", {63'b0, tx}, 64'd1);
    chk("rst_irq", {63'b0, timer_interrupt}, 64'd0);

    access(TB_BASE + 32'h8, 32'h0, 1'b0, 1'b1, "rst_cmp_lo");
    access(TB_BASE + 32'hC, 32'h0, 1'b0, 1'b1, "rst_cmp_hi");
    access(TB_BASE + 32'h0, 32'h0, 1'b0, 1'b1, "mtime_lo_a");
    idle($urandom_range(5, 40));
    access(TB_BASE + 32'h0, 32'h0, 1'b0, 1'b1, "mtime_lo_b");
    access(TB_BASE + 32'h4, 32'h0, 1'b0, 1'b1, "mtime_hi");

    // Interrupt fires 20 cycles after arming, then clears when the compare moves away.
    access(TB_BASE + 32'hC, 32'h0, 1'b1, 1'b0, "cmp_hi_w");
    tmp = mtime_at(cyc + 1);
    tgt = tmp[31:0] + 32'd20;
    access(TB_BASE + 32'h8, tgt, 1'b1, 1'b0, "cmp_lo_w");
    idle(30);
    access(TB_BASE + 32'h8, 32'hFFFF_FFFF, 1'b1, 1'b0, "cmp_lo_max");
    idle(5);

    // Carry from the low half and full 64-bit wrap.
    access(TB_BASE + 32'h4, 32'h0, 1'b1, 1'b0, "mt_hi_w0");
    access(TB_BASE + 32'h0, 32'hFFFF_FFFE, 1'b1, 1'b0, "mt_lo_wfe");
    idle(2);
    access(TB_BASE + 32'h4, 32'h0, 1'b0, 1'b1, "carry_hi");
    access(TB_BASE + 32'h4, 32'hFFFF_FFFF, 1'b1, 1'b0, "mt_hi_w1");
    access(TB_BASE + 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, "mt_lo_w1");
    access(TB_BASE + 32'h0, 32'h0, 1'b0, 1'b1, "wrap_lo");
    access(TB_BASE + 32'h4, 32'h0, 1'b0, 1'b1, "wrap_hi");
    idle(3);

    // UART 0x55 with STATUS polled every cycle of the frame and just past it.
    access(UB_BASE, 32'h55, 1'b1, 1'b0, "tx55");
    for (int i = 0; i < 170; i++) access(UB_BASE + 32'h4, 32'h0, 1'b0, 1'b1, "status55");
    idle(3);

    // A write while busy is dropped; the first free cycle accepts the retry.
    access(UB_BASE, 32'hA5, 1'b1, 1'b0, "txA5");
    idle(50);
    access(UB_BASE, 32'h3C, 1'b1, 1'b0, "tx3C_drop");
    access(UB_BASE + 32'h0, 32'h0, 1'b0, 1'b1, "txdata_rd");
    for (int i = 0; i < 400 && busy_at(cyc + 1); i++) idle(1);
    access(UB_BASE, 32'h3C, 1'b1, 1'b0, "tx3C");
    idle(FRAME + 5);

    // Decode corners and ignored writes.
    access(UB_BASE + 32'h8, 32'h0, 1'b0, 1'b1, "dec_uart8");
    access(TB_BASE + 32'h10, 32'h0, 1'b0, 1'b1, "dec_timer10");
    access(UB_BASE + 32'h4, 32'h0, 1'b0, 1'b1, "dec_status");
    access(UB_BASE + 32'h4, 32'hFFFF_FFFF, 1'b1, 1'b0, "status_w");
    access(TB_BASE + 32'h10, 32'h1234_5678, 1'b1, 1'b0, "unmapped_w");
    access(TB_BASE + 32'h0, 32'h0, 1'b0, 1'b1, "after_unmapped");
    access(TB_BASE + 32'h1, 32'h0, 1'b0, 1'b1, "byte_off_ign");
    access(TB_BASE + 32'h0, 32'hCAFE_0000, 1'b1, 1'b1, "rw_same");
    access(TB_BASE + 32'h0, 32'h0, 1'b0, 1'b1, "rw_after");
    idle(2);

    // Randomized mix of timer/UART/unmapped accesses.
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: ra = TB_BASE;
        1: ra = TB_BASE + 32'h4;
        2: ra = TB_BASE + 32'h8;
        3: ra = TB_BASE + 32'hC;
        4: ra = UB_BASE;
        5: ra = UB_BASE + 32'h4;
        6: ra = UB_BASE + 32'h8;
        7: ra = TB_BASE + 32'h10;
        8: ra = TB_BASE - 32'h4;
        default: ra = $urandom;
      endcase
      access(ra, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 20));
    end
    idle(FRAME + 5);

    // Reset in the middle of a start bit drops the line high at once.
    access(UB_BASE, 32'hF0, 1'b1, 1'b0, "txF0");
    idle(10);
    @(posedge clk); #3;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("rstmid_tx", {63'b0, tx}, 64'd1);
    chk("rstmid_irq", {63'b0, timer_interrupt}, 64'd0);
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset(cyc);
    mon_en = 1'b1;
    idle(20);
    access(TB_BASE + 32'h0, 32'h0, 1'b0, 1'b1, "post_rst_mtime");
    access(UB_BASE + 32'h4, 32'h0, 1'b0, 1'b1, "post_rst_status");
    idle(FRAME + 5);

    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL rd_drain: got %0d pending expectations, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_uart_periph.md
# timer_uart_periph

Memory-mapped peripheral block on the CPU data bus. It holds a RISC-V machine timer (64-bit mtime/mtimecmp) that drives the CPU `timer_interrupt`, and a transmit-only 8N1 UART. It sits beside unified memory in `top` and decodes its own address windows. Read data is combinational and is muxed into the CPU load path.

## Interface
- `TIMER_BASE`, default 32'h0200_0000: base of the 16-byte timer window.
- `UART_BASE`, default 32'h1000_0000: base of the 8-byte UART window.
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit, must be ≥2.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `addr` in 32: byte address, word-aligned; bits [1:0] are ignored.
- `write_data` in 32: store data.
- `write_enable` in 1: store strobe.
- `read_enable` in 1: load strobe.
- `read_data` out 32: combinational load data.
- `timer_valid` out 1: access hits a mapped timer register.
- `uart_valid` out 1: access hits a mapped UART register.
- `timer_interrupt` out 1: machine timer interrupt level.
- `tx` out 1: UART serial output, idle high.

## Operation
- Timer registers, offset from `TIMER_BASE`: +0x0 mtime[31:0], +0x4 mtime[63:32], +0x8 mtimecmp[31:0], +0xC mtimecmp[63:32]. All are read/write.
- mtime increments by 1 every cycle and wraps from 2^64−1 to 0.
- A write to an mtime half replaces that half in that cycle. The written value is stored with no increment that cycle. The other half holds.
- `timer_interrupt` is 1 when the stored mtime ≥ the stored mtimecmp, as an unsigned 64-bit compare. The output is registered.
- UART registers, offset from `UART_BASE`: +0x0 TXDATA, +0x4 STATUS.
  - TXDATA is write-only; reads return 0.
  - STATUS is read-only: bit0 = busy, all other bits 0.
- A TXDATA write when not busy latches `write_data[7:0]` and starts a frame.
- A TXDATA write while busy is dropped. STATUS writes are ignored.
- Frame format: start bit 0, then data bits LSB first, then stop bit 1. Each bit lasts `CLKS_PER_BIT` cycles.
- busy stays high from the cycle after the accepting write until the stop bit completes.
- UART FSM states: IDLE → START → DATA (8 bits, 3-bit index) → STOP → IDLE.
- Valid strobes: `timer_valid` / `uart_valid` = (`read_enable` | `write_enable`) and `addr` falls on a mapped offset in that window.
- `read_data` = the selected register when `read_enable` is high and the access is valid; otherwise 0.
- Unmapped offsets inside a window: reads return 0, writes are ignored, valid stays 0.

## Timing
- Reset values: mtime 0, mtimecmp 64'hFFFF_FFFF_FFFF_FFFF, `timer_interrupt` 0, `tx` 1, busy 0, FSM IDLE.
- `read_data`, `timer_valid` and `uart_valid` are combinational and are 0 when there is no access.
- Read latency is 0 cycles. A read of mtime returns the value before that edge's increment.
- `timer_interrupt` rises one cycle after the compare condition first holds. It stays high until mtimecmp is rewritten above mtime, or until mtime wraps.
- UART timing:
  - `tx` goes low on the edge after the accepting write.
  - A frame lasts 10×`CLKS_PER_BIT` cycles.
  - A new TXDATA write is accepted in the first cycle after busy falls.
- Reset asserted mid-frame: `tx` returns to 1 immediately and the byte is lost.
- Simultaneous `read_enable` and `write_enable`: both act on the same `addr`. The read returns the pre-write value.

## Structure
- Shared package `periph_pkg`:
  - register offset constants (TIMER_MTIME_LO/HI, TIMER_MTIMECMP_LO/HI, UART_TXDATA, UART_STATUS);
  - the UART state enum.
- Sub-module `uart_tx`: byte-in/start/busy/tx serializer, parameterized by `CLKS_PER_BIT`.
- The timer and the bus decode stay in the top-level block.

## Test plan
- Reset: hold `rst`=0 for 3 cycles, then release → `tx`=1, `timer_interrupt`=0. A read of mtimecmp_lo returns 32'hFFFF_FFFF. Two mtime_lo reads taken N cycles apart differ by N.
- Interrupt:
  - write mtimecmp_hi=0, then mtimecmp_lo = current mtime+20 → `timer_interrupt` rises 20±1 cycles later;
  - then write mtimecmp_lo=32'hFFFF_FFFF → the interrupt clears within 1 cycle.
- Carry/wrap: write mtime_hi=0, mtime_lo=32'hFFFF_FFFE → mtime_hi reads 1 within 3 cycles. Write both halves as all ones → mtime reads 0/0 on the next cycle.
- UART byte: write 0x55 to TXDATA with `CLKS_PER_BIT`=16 → `tx` sequence 0,1,0,1,0,1,0,1,0,1, each bit held 16 cycles. STATUS bit0 reads 1 for 160 cycles, then 0.
- UART busy drop: write 0xA5, then write 0x3C mid-frame → only 0xA5 is transmitted. The next accepted write after busy falls sends 0x3C.
- Decode: read UART_BASE+0x8 and TIMER_BASE+0x10 → `read_data`=0, both valid strobes 0. Read of UART STATUS → `uart_valid`=1, `timer_valid`=0.
